store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 11 +
 rtl/store_buffer_sb_fifo.sv | 60 ++++++
 rtl/store_buffer.sv | 98 +++++++++
 tb/tb_store_buffer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default depth and the buffered entry layout.
package store_buffer_pkg;

  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_sb_fifo.sv
// Circular FIFO of buffered stores with head/tail pointers, occupancy count and an
// in-place data update port used when a new store coalesces into an existing entry.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  sb_entry_t                      push_entry,
  input  logic                           pop,
  input  logic                           upd,
  input  logic [$clog2(DEPTH)-1:0]       upd_idx,
  input  logic [31:0]                    upd_data,
  output sb_entry_t [DEPTH-1:0]          entries,
  output logic [DEPTH-1:0]               valid,
  output logic [$clog2(DEPTH)-1:0]       head,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         tail;

  assign entries = mem;

  // Entry storage carries no reset; validity comes only from head/count.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= push_entry;
    if (upd) mem[upd_idx].data <= upd_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CW'(PW'(i) - head) < count);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write buffer between CPU and data memory: queues stores, forwards them to loads,
// coalesces same-word stores and drains to memory whenever the port is free.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        empty,
  output logic        mwr,
  output logic        moe,
  output logic [31:0] ma,
  output logic [31:0] mwd,
  input  logic [31:0] mrd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         head;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  drain;
  logic                  accept;
  logic                  hit;
  logic [PW-1:0]         hit_idx;
  logic                  coalesce;
  logic                  push;
  sb_entry_t             push_entry;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // Reset suppresses the drain so buffered stores are discarded, not written.
  assign drain     = !empty && (!cpu_rd || full) && !reset;
  assign cpu_stall = !reset && full && (cpu_rd || cpu_wr);
  assign accept    = cpu_wr && !cpu_stall;

  // At most one live entry can hold a given word, so the last hit is the only hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].word_addr == cpu_addr[31:2])) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // A head that leaves memory this cycle cannot absorb the new data.
  assign coalesce             = accept && hit && !((hit_idx == head) && drain);
  assign push                 = accept && !coalesce;
  assign push_entry.word_addr = cpu_addr[31:2];
  assign push_entry.data      = cpu_wdata;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (drain),
    .upd        (coalesce),
    .upd_idx    (hit_idx),
    .upd_data   (cpu_wdata),
    .entries    (entries),
    .valid      (valid),
    .head       (head),
    .count      (count)
  );

  always_comb begin
    cpu_rdata = '0;
    if (cpu_rd) cpu_rdata = hit ? entries[hit_idx].data : mrd;
  end

  always_comb begin
    mwr = 1'b0;
    moe = cpu_rd;
    ma  = cpu_addr;
    mwd = '0;
    if (drain) begin
      mwr = 1'b1;
      moe = 1'b0;
      ma  = {entries[head].word_addr, 2'b00};
      mwd = entries[head].data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a behavioural data memory plus a queue of expected
// memory writes that a write monitor pops and compares.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        empty;
  logic        mwr;
  logic        moe;
  logic [31:0] ma;
  logic [31:0] mwd;
  logic [31:0] mrd;

  logic [31:0] dmem [256];
  logic [63:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  store_buffer #(.DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .empty     (empty),
    .mwr       (mwr),
    .moe       (moe),
    .ma        (ma),
    .mwd       (mwd),
    .mrd       (mrd)
  );

  function automatic logic [31:0] init_val(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial for (int i = 0; i < 256; i++) dmem[i] = init_val(i);
  assign mrd = dmem[ma[9:2]];
  always @(posedge clock) if (mwr === 1'b1) dmem[ma[9:2]] <= mwd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every memory write must be the next one the scoreboard expects.
  always @(negedge clock) begin
    if (mwr === 1'b1) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("write_addr_data", {ma, mwd}, exp_q.pop_front());
    end
  end

  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clock);
    #1;
    reset     = rst;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #3;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset and post-reset port state
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_mwr", 64'(mwr), 64'd0);
    step(0, 1, 0, 32'h48, 32'h0);
    chk("post_rst_empty", 64'(empty), 64'd1);
    chk("post_rst_mwr", 64'(mwr), 64'd0);
    chk("post_rst_moe", 64'(moe), 64'd1);
    chk("post_rst_ma", 64'(ma), 64'h48);
    chk("post_rst_mwd", 64'(mwd), 64'd0);
    chk("post_rst_rdata", 64'(cpu_rdata), 64'(init_val(18)));
    idle();
    chk("idle_rdata_zero", 64'(cpu_rdata), 64'd0);
    chk("idle_moe", 64'(moe), 64'd0);

    // Single store drains on the next cycle
    exp_q.push_back({32'h8, 32'h11});
    step(0, 0, 1, 32'h8, 32'h11);
    chk("s1_no_write_yet", 64'(mwr), 64'd0);
    idle();
    chk("s1_mwr", 64'(mwr), 64'd1);
    chk("s1_ma", 64'(ma), 64'h8);
    chk("s1_mwd", 64'(mwd), 64'h11);
    idle();
    chk("s1_empty", 64'(empty), 64'd1);

    // Forward to a load with nonzero byte offset; load blocks the drain
    exp_q.push_back({32'h10, 32'hAA});
    step(0, 0, 1, 32'h10, 32'hAA);
    step(0, 1, 0, 32'h12, 32'h0);
    chk("fwd_rdata", 64'(cpu_rdata), 64'hAA);
    chk("fwd_mwr", 64'(mwr), 64'd0);
    chk("fwd_moe", 64'(moe), 64'd1);
    chk("fwd_empty", 64'(empty), 64'd0);
    idle();
    chk("fwd_drain", 64'(mwr), 64'd1);
    idle();
    chk("fwd_empty_after", 64'(empty), 64'd1);

    // Fill under continuous loads, then a fifth store stalls behind the drain
    exp_q.push_back({32'h0, 32'h100});
    exp_q.push_back({32'h4, 32'h101});
    exp_q.push_back({32'h8, 32'h102});
    exp_q.push_back({32'hC, 32'h103});
    exp_q.push_back({32'h30, 32'h104});
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 32'(4 * i), 32'h100 + 32'(i));
      chk("fill_no_drain", 64'(mwr), 64'd0);
    end
    step(0, 1, 1, 32'h30, 32'h104);
    chk("full_stall", 64'(cpu_stall), 64'd1);
    chk("full_mwr", 64'(mwr), 64'd1);
    chk("full_moe", 64'(moe), 64'd0);
    chk("full_ma", 64'(ma), 64'h0);
    step(0, 1, 1, 32'h30, 32'h104);
    chk("retry_stall", 64'(cpu_stall), 64'd0);
    chk("retry_mwr", 64'(mwr), 64'd0);
    step(0, 1, 0, 32'h4, 32'h0);
    chk("refull_stall", 64'(cpu_stall), 64'd1);
    chk("refull_ma", 64'(ma), 64'h4);
    chk("refull_fwd", 64'(cpu_rdata), 64'h101);
    repeat (4) idle();
    chk("fill_empty", 64'(empty), 64'd1);

    // Two stores to one word coalesce into a single drain
    exp_q.push_back({32'h20, 32'h2});
    step(0, 1, 1, 32'h20, 32'h1);
    chk("co_rdata_mem", 64'(cpu_rdata), 64'(init_val(8)));
    step(0, 1, 1, 32'h20, 32'h2);
    chk("co_rdata_old", 64'(cpu_rdata), 64'h1);
    step(0, 1, 0, 32'h20, 32'h0);
    chk("co_rdata_new", 64'(cpu_rdata), 64'h2);
    idle();
    chk("co_drain_mwd", 64'(mwd), 64'h2);
    idle();
    chk("co_empty", 64'(empty), 64'd1);

    // Store hitting the head while it drains enqueues a second write
    exp_q.push_back({32'h40, 32'hA1});
    exp_q.push_back({32'h40, 32'hA2});
    step(0, 0, 1, 32'h42, 32'hA1);
    step(0, 0, 1, 32'h41, 32'hA2);
    chk("hd_first_mwd", 64'(mwd), 64'hA1);
    chk("hd_first_ma", 64'(ma), 64'h40);
    idle();
    chk("hd_second_mwd", 64'(mwd), 64'hA2);
    idle();
    chk("hd_empty", 64'(empty), 64'd1);

    // Reset with three buffered stores discards them without writing
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h50 + 32'(4 * i), 32'hB0 + 32'(i));
    step(1, 0, 1, 32'h50, 32'h0);
    chk("rst_drain_mwr", 64'(mwr), 64'd0);
    chk("rst_drain_stall", 64'(cpu_stall), 64'd0);
    step(0, 1, 0, 32'h54, 32'h0);
    chk("rst_drop_empty", 64'(empty), 64'd1);
    chk("rst_drop_rdata", 64'(cpu_rdata), 64'(init_val(21)));
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
